// File: rtl/lc3_regfile_scoreboard.sv
// LC-3 register file with two combinational read ports, one write port, a pending-write
// scoreboard and the NZP condition-code register. Define WRITE_BYPASS_EN for write-to-read forwarding.
module lc3_regfile_scoreboard #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   localparam int ADDR_W  = $clog2(NUM_REGS)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              clear_all,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              cc_en,
   input  logic              busy_set,
   input  logic [ADDR_W-1:0] busy_addr,
   input  logic [ADDR_W-1:0] rd1_addr,
   input  logic [ADDR_W-1:0] rd2_addr,
   output logic [DATA_W-1:0] rd1_data,
   output logic [DATA_W-1:0] rd2_data,
   output logic              rd1_busy,
   output logic              rd2_busy,
   output logic [2:0]        nzp,
   output logic              sb_err
);

   localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_REGS);

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_next;
   logic [2:0]          nzp_next;
   logic                wr_ok;
   logic                bs_ok;
   logic                rd1_ok;
   logic                rd2_ok;
   logic                sb_hit;

   // Addresses beyond the last register exist only when NUM_REGS is not a power of two.
   assign wr_ok  = wr_en    && ({1'b0, wr_addr}   < LIMIT);
   assign bs_ok  = busy_set && ({1'b0, busy_addr} < LIMIT);
   assign rd1_ok = ({1'b0, rd1_addr} < LIMIT);
   assign rd2_ok = ({1'b0, rd2_addr} < LIMIT);

   always_comb begin
      busy_next = busy;
      if (wr_ok) busy_next[wr_addr] = 1'b0;
      if (bs_ok) busy_next[busy_addr] = 1'b1;
      sb_hit = bs_ok && busy[busy_addr] && !(wr_ok && (wr_addr == busy_addr));
   end

   always_comb begin
      nzp_next = nzp;
      if (wr_ok && cc_en) begin
         if (wr_data[DATA_W-1])    nzp_next = 3'b100;
         else if (wr_data == '0)   nzp_next = 3'b010;
         else                      nzp_next = 3'b001;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         busy   <= '0;
         nzp    <= 3'b010;
         sb_err <= 1'b0;
      end else if (clear_all) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         busy   <= '0;
         nzp    <= 3'b010;
         sb_err <= 1'b0;
      end else begin
         if (wr_ok) regs[wr_addr] <= wr_data;
         busy <= busy_next;
         nzp  <= nzp_next;
         if (sb_hit) sb_err <= 1'b1;
      end
   end

   always_comb begin
      rd1_data = '0;
      rd1_busy = 1'b0;
      rd2_data = '0;
      rd2_busy = 1'b0;
      if (rd1_ok) begin
         rd1_data = regs[rd1_addr];
         rd1_busy = busy[rd1_addr];
      end
      if (rd2_ok) begin
         rd2_data = regs[rd2_addr];
         rd2_busy = busy[rd2_addr];
      end
`ifdef WRITE_BYPASS_EN
      // Forward the in-flight write so a dependent read need not wait for the edge.
      if (wr_ok && !clear_all && (wr_addr == rd1_addr)) begin
         rd1_data = wr_data;
         rd1_busy = 1'b0;
      end
      if (wr_ok && !clear_all && (wr_addr == rd2_addr)) begin
         rd2_data = wr_data;
         rd2_busy = 1'b0;
      end
`endif
   end

endmodule
